// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl (with helper uart_ctrl_fifo)
// Summary  : Bus-mapped controller sequencing one uart_core through TX/RX
//            FIFOs. Optional interrupt output enabled by UART_CTRL_IRQ_EN.
// Revision : 1.0
// ============================================================================

module uart_ctrl_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(c_depth);

    logic [7:0]            mem_q [c_depth];
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  w_push;
    logic                  w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_full_count);
    assign head_o  = mem_q[rptr_q];
    // A pop frees the slot first, so a push into a full FIFO succeeds alongside it
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end
endmodule

module uart_ctrl #(
    parameter int          TX_DEPTH_LOG2 = 2,
    parameter int          RX_DEPTH_LOG2 = 2,
    parameter logic [11:0] DIV_RESET     = 12'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [11:0] divider,
    output logic [7:0]  data_tx,
    output logic        have_data_tx,
    input  logic        transmitting,
    input  logic [7:0]  data_rx,
    input  logic        have_data_rx,
`ifdef UART_CTRL_IRQ_EN
    output logic        irq,
`endif
    output logic        data_rx_ack
);
    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_div_lo = 2'd2;
    localparam logic [1:0] c_addr_div_hi = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_WAITHI = 2'd2,
        TX_WAITLO = 2'd3
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  data_tx_q, data_tx_d;
    logic        data_rx_ack_q, data_rx_ack_d;
    logic        overrun_q, overrun_d;
    logic [11:0] divider_q, divider_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        w_wr_data, w_wr_status, w_wr_div_lo, w_wr_div_hi;
    logic        w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]  w_tx_head;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_avail;
    logic [7:0]  w_rx_head;
    logic        w_overrun_set;
    logic        w_busy;
    logic [1:0]  w_ie_bits;
    logic [7:0]  w_status;

    assign w_wr_data   = wr && (addr == c_addr_data);
    assign w_wr_status = wr && (addr == c_addr_status);
    assign w_wr_div_lo = wr && (addr == c_addr_div_lo);
    assign w_wr_div_hi = wr && (addr == c_addr_div_hi);
    assign w_rx_pop    = rd && (addr == c_addr_data) && !w_rx_empty;
    assign w_rx_avail  = ~w_rx_empty;
    assign w_busy      = transmitting || (tx_state_q != TX_IDLE);
    assign w_status    = {w_ie_bits, w_busy, overrun_q, w_rx_full,
                          w_rx_avail, w_tx_empty, w_tx_full};

    uart_ctrl_fifo #(
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_wr_data),
        .pop_i   (w_tx_pop),
        .wdata_i (wdata),
        .head_o  (w_tx_head),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty)
    );

    uart_ctrl_fifo #(
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_rx_push),
        .pop_i   (w_rx_pop),
        .wdata_i (data_rx),
        .head_o  (w_rx_head),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        data_tx_d  = data_tx_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop   = 1'b1;
                    data_tx_d  = w_tx_head;
                    tx_state_d = TX_LAUNCH;
                end
            end
            TX_LAUNCH: tx_state_d = TX_WAITHI;
            TX_WAITHI: begin
                if (transmitting) begin
                    tx_state_d = TX_WAITLO;
                end
            end
            TX_WAITLO: begin
                if (!transmitting) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Ack is registered so it is high during RX_ACK; the core drops
    // have_data_rx before the FSM returns to RX_IDLE.
    always_comb begin
        rx_state_d    = rx_state_q;
        data_rx_ack_d = 1'b0;
        w_rx_push     = 1'b0;
        w_overrun_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (have_data_rx) begin
                    if (!w_rx_full || w_rx_pop) begin
                        w_rx_push = 1'b1;
                    end else begin
                        w_overrun_set = 1'b1;
                    end
                    data_rx_ack_d = 1'b1;
                    rx_state_d    = RX_ACK;
                end
            end
            RX_ACK:  rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (w_overrun_set) begin
            overrun_d = 1'b1;
        end else if (w_wr_status && wdata[4]) begin
            overrun_d = 1'b0;
        end

        divider_d = divider_q;
        if (w_wr_div_lo) begin
            divider_d[7:0] = wdata;
        end
        if (w_wr_div_hi) begin
            divider_d[11:8] = wdata[3:0];
        end

        rdata_d = rdata_q;
        if (rd) begin
            case (addr)
                c_addr_data:   rdata_d = w_rx_empty ? 8'h00 : w_rx_head;
                c_addr_status: rdata_d = w_status;
                c_addr_div_lo: rdata_d = divider_q[7:0];
                c_addr_div_hi: rdata_d = {4'h0, divider_q[11:8]};
                default:       rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            rx_state_q    <= RX_IDLE;
            data_tx_q     <= 8'h00;
            data_rx_ack_q <= 1'b0;
            overrun_q     <= 1'b0;
            divider_q     <= DIV_RESET;
            rdata_q       <= 8'h00;
        end else begin
            tx_state_q    <= tx_state_d;
            rx_state_q    <= rx_state_d;
            data_tx_q     <= data_tx_d;
            data_rx_ack_q <= data_rx_ack_d;
            overrun_q     <= overrun_d;
            divider_q     <= divider_d;
            rdata_q       <= rdata_d;
        end
    end

`ifdef UART_CTRL_IRQ_EN
    logic [1:0] ie_q, ie_d;
    logic       irq_q, irq_d;

    // ie bit1 = tx_empty enable, bit0 = rx_avail enable
    always_comb begin
        ie_d = ie_q;
        if (w_wr_status) begin
            ie_d = wdata[7:6];
        end
        irq_d = (ie_q[0] & w_rx_avail)
              | (ie_q[1] & w_tx_empty & ~w_busy)
              | overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign w_ie_bits = ie_q;
`else
    assign w_ie_bits = 2'b00;
`endif

    assign rdata        = rdata_q;
    assign divider      = divider_q;
    assign data_tx      = data_tx_q;
    assign have_data_tx = (tx_state_q == TX_LAUNCH);
    assign data_rx_ack  = data_rx_ack_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ctrl
// Summary  : Directed self-checking bench for uart_ctrl with a uart_core model.
// Revision : 1.0
// ============================================================================
module tb_uart_ctrl;
    localparam int TX_LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic [11:0] divider;
    logic [7:0]  data_tx;
    logic        have_data_tx;
    logic        transmitting = 1'b0;
    logic [7:0]  data_rx = 8'h00;
    logic        have_data_rx = 1'b0;
    logic        data_rx_ack;

    int         total = 0;
    int         bad = 0;
    int         ack_cnt = 0;
    int         tx_timer = 0;
    logic [7:0] tx_log[$];

    uart_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wr           (wr),
        .rd           (rd),
        .wdata        (wdata),
        .rdata        (rdata),
        .divider      (divider),
        .data_tx      (data_tx),
        .have_data_tx (have_data_tx),
        .transmitting (transmitting),
        .data_rx      (data_rx),
        .have_data_rx (have_data_rx),
        .data_rx_ack  (data_rx_ack)
    );

    always #5 clk = ~clk;

    // uart_core TX side: transmitting rises the cycle after the launch pulse
    always @(posedge clk) begin
        if (rst) begin
            transmitting <= 1'b0;
            tx_timer     <= 0;
        end else if (have_data_tx) begin
            tx_log.push_back(data_tx);
            transmitting <= 1'b1;
            tx_timer     <= TX_LEN;
        end else if (transmitting) begin
            if (tx_timer == 0) transmitting <= 1'b0;
            else tx_timer <= tx_timer - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && data_rx_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic deliver(input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        data_rx = b; have_data_rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_rx_ack) begin
                seen = 1'b1;
                break;
            end
        end
        have_data_rx = 1'b0;
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL rx_ack_timeout byte=%h: got seen=%b want 1", b, seen);
        end
        @(negedge clk);
    endtask

    task automatic wait_tx_idle(output logic [7:0] s);
        for (int i = 0; i < 150; i++) begin
            bus_read(2'd1, s);
            if (s == 8'h02) break;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        total++; if (divider !== 12'd103) begin bad++; $display("FAIL reset_divider: got %h want 067", divider); end
        total++; if (data_tx !== 8'h00) begin bad++; $display("FAIL reset_data_tx: got %h want 00", data_tx); end
        total++; if (have_data_tx !== 1'b0) begin bad++; $display("FAIL reset_have_data_tx: got %b want 0", have_data_tx); end
        total++; if (data_rx_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", data_rx_ack); end
        rst = 1'b0;
        bus_read(2'd1, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL reset_status: got %h want 02", d); end
        bus_read(2'd2, d);
        total++; if (d !== 8'h67) begin bad++; $display("FAIL reset_div_lo: got %h want 67", d); end
        bus_read(2'd3, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_div_hi: got %h want 00", d); end
    endtask

    task automatic test_divider();
        logic [7:0] d;
        bus_write(2'd3, 8'h1A);
        total++; if (divider !== 12'hA67) begin bad++; $display("FAIL div_hi_write: got %h want a67", divider); end
        bus_read(2'd3, d);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL div_hi_read: got %h want 0a", d); end
        bus_write(2'd2, 8'h04);
        bus_write(2'd3, 8'h00);
        total++; if (divider !== 12'h004) begin bad++; $display("FAIL div_final: got %h want 004", divider); end
    endtask

    task automatic test_single_tx();
        logic [7:0] s;
        tx_log.delete();
        bus_write(2'd0, 8'hA5);
        repeat (3) @(negedge clk);
        bus_read(2'd1, s);
        total++; if (s !== 8'h22) begin bad++; $display("FAIL tx_busy_status: got %h want 22", s); end
        wait_tx_idle(s);
        total++; if (s !== 8'h02) begin bad++; $display("FAIL tx_idle_status: got %h want 02", s); end
        total++; if (tx_log.size() !== 1) begin bad++; $display("FAIL tx_pulse_count: got %0d want 1", tx_log.size()); end
        if (tx_log.size() > 0) begin
            total++; if (tx_log[0] !== 8'hA5) begin bad++; $display("FAIL tx_byte: got %h want a5", tx_log[0]); end
        end
        total++; if (data_tx !== 8'hA5) begin bad++; $display("FAIL tx_data_hold: got %h want a5", data_tx); end
    endtask

    task automatic test_tx_fill();
        logic [7:0] s;
        logic [7:0] got;
        tx_log.delete();
        for (int i = 1; i <= 6; i++) bus_write(2'd0, 8'(i));
        bus_read(2'd1, s);
        total++; if (s !== 8'h21) begin bad++; $display("FAIL tx_full_status: got %h want 21", s); end
        wait_tx_idle(s);
        total++; if (s !== 8'h02) begin bad++; $display("FAIL tx_fill_idle: got %h want 02", s); end
        total++; if (tx_log.size() !== 5) begin bad++; $display("FAIL tx_fill_count: got %0d want 5", tx_log.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            total++;
            if (got !== 8'(i + 1)) begin bad++; $display("FAIL tx_order[%0d]: got %h want %h", i, got, 8'(i + 1)); end
        end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        int a0;
        a0 = ack_cnt;
        deliver(8'h3C);
        deliver(8'hC3);
        total++; if (ack_cnt - a0 !== 2) begin bad++; $display("FAIL rx_ack_count: got %0d want 2", ack_cnt - a0); end
        bus_read(2'd1, d);
        total++; if (d !== 8'h06) begin bad++; $display("FAIL rx_avail_status: got %h want 06", d); end
        bus_read(2'd0, d);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rx_byte0: got %h want 3c", d); end
        bus_read(2'd0, d);
        total++; if (d !== 8'hC3) begin bad++; $display("FAIL rx_byte1: got %h want c3", d); end
        bus_read(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rx_empty_read: got %h want 00", d); end
        bus_read(2'd1, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL rx_drained_status: got %h want 02", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int a0;
        a0 = ack_cnt;
        for (int i = 0; i < 5; i++) deliver(8'h11 + 8'(i));
        total++; if (ack_cnt - a0 !== 5) begin bad++; $display("FAIL ovr_ack_count: got %0d want 5", ack_cnt - a0); end
        bus_read(2'd1, d);
        total++; if (d !== 8'h1E) begin bad++; $display("FAIL ovr_status: got %h want 1e", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, d);
            total++;
            if (d !== 8'h11 + 8'(i)) begin bad++; $display("FAIL ovr_byte[%0d]: got %h want %h", i, d, 8'h11 + 8'(i)); end
        end
        bus_read(2'd1, d);
        total++; if (d !== 8'h12) begin bad++; $display("FAIL ovr_sticky: got %h want 12", d); end
        bus_write(2'd1, 8'h10);
        bus_read(2'd1, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL ovr_clear: got %h want 02", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int n;
        tx_log.delete();
        bus_write(2'd0, 8'h11);
        bus_write(2'd0, 8'h22);
        bus_write(2'd0, 8'h33);
        for (int i = 0; i < 20 && !transmitting; i++) @(negedge clk);
        total++; if (transmitting !== 1'b1) begin bad++; $display("FAIL mid_tx_start: got %b want 1", transmitting); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata: got %h want 00", rdata); end
        total++; if (divider !== 12'd103) begin bad++; $display("FAIL mid_divider: got %h want 067", divider); end
        total++; if (data_tx !== 8'h00) begin bad++; $display("FAIL mid_data_tx: got %h want 00", data_tx); end
        total++; if (have_data_tx !== 1'b0) begin bad++; $display("FAIL mid_have_data_tx: got %b want 0", have_data_tx); end
        total++; if (data_rx_ack !== 1'b0) begin bad++; $display("FAIL mid_ack: got %b want 0", data_rx_ack); end
        rst = 1'b0;
        n = tx_log.size();
        repeat (60) @(negedge clk);
        total++; if (tx_log.size() !== n) begin bad++; $display("FAIL mid_no_launch: got %0d want %0d", tx_log.size(), n); end
        bus_read(2'd1, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL mid_status: got %h want 02", d); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_single_tx();
        test_tx_fill();
        test_rx();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
